// File: rtl/jump_inject_ctrl_if.sv
// Command/response bus for jump_inject_ctrl.
// master: the agent that issues jump commands and collects the captured core state.
// slave:  the controller itself.
interface jump_inject_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_target;
  logic [15:0] cmd_count;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_jout;
  logic [8:0]  rsp_pco;
  logic [8:0]  rsp_link;
  logic [1:0]  rsp_status;

  modport master (
    output cmd_valid, cmd_target, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_jout, rsp_pco, rsp_link, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_jout, rsp_pco, rsp_link, rsp_status
  );
endinterface

// File: rtl/jump_inject_ctrl.sv
// jump_inject_ctrl: queues {target, count} commands, injects a one-cycle jump
// (Jen/Jin) into the core, waits for `count` InstDone pulses, then captures the
// core's Jout/pco/link into a held response.
// Optional feature macro: JUMP_INJECT_TIMEOUT_EN -- when defined, a RUN phase
// that sees no InstDone for TIMEOUT_CYCLES cycles is cut short and answered
// with rsp_status = 2'b01.
module jump_inject_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  jump_inject_ctrl_if.slave   bus,
  output logic                Jen,
  output logic [31:0]         Jin,
  input  logic                InstDone,
  input  logic [31:0]         Jout,
  input  logic [8:0]          pco,
  input  logic [8:0]          link
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = AW + 1;

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("jump_inject_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("jump_inject_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_INJECT, S_RUN, S_CAPTURE, S_RESP
  } state_t;

  state_t            state_q;
  logic [31:0]       mem_tgt [FIFO_DEPTH];
  logic [15:0]       mem_cnt [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [15:0]       cnt_q;
  logic              full, push, pop;

  logic              rsp_valid_q;
  logic [31:0]       rsp_jout_q;
  logic [8:0]        rsp_pco_q, rsp_link_q;
  logic [1:0]        rsp_status_q;

  // Ready depends only on registered occupancy (and reset), never on this cycle's pop.
  assign full          = (occ_q == OCC_W'(FIFO_DEPTH));
  assign bus.cmd_ready = !full && !rst;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state_q == S_IDLE) && (occ_q != '0);

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_jout   = rsp_jout_q;
  assign bus.rsp_pco    = rsp_pco_q;
  assign bus.rsp_link   = rsp_link_q;
  assign bus.rsp_status = rsp_status_q;

  // Command storage; entries are not reset, occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tgt[wr_ptr_q] <= bus.cmd_target;
      mem_cnt[wr_ptr_q] <= bus.cmd_count;
    end
  end

  // Circular pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef JUMP_INJECT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit_q;
`endif

  // Sequencer: IDLE -> INJECT -> (RUN) -> CAPTURE -> RESP -> IDLE, outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      Jen          <= 1'b0;
      Jin          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_jout_q   <= '0;
      rsp_pco_q    <= '0;
      rsp_link_q   <= '0;
      rsp_status_q <= 2'b00;
`ifdef JUMP_INJECT_TIMEOUT_EN
      tmo_q        <= '0;
      tmo_hit_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cnt_q   <= mem_cnt[rd_ptr_q];
            Jen     <= 1'b1;
            Jin     <= mem_tgt[rd_ptr_q];
            state_q <= S_INJECT;
          end
        end
        S_INJECT: begin
          // InstDone in this cycle belongs to the jump itself and is not counted.
          Jen     <= 1'b0;
          Jin     <= '0;
`ifdef JUMP_INJECT_TIMEOUT_EN
          tmo_q     <= '0;
          tmo_hit_q <= 1'b0;
`endif
          state_q <= (cnt_q != 16'd0) ? S_RUN : S_CAPTURE;
        end
        S_RUN: begin
          if (InstDone) begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_q <= S_CAPTURE;
`ifdef JUMP_INJECT_TIMEOUT_EN
            tmo_q <= '0;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit_q <= 1'b1;
            state_q   <= S_CAPTURE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        S_CAPTURE: begin
          rsp_jout_q   <= Jout;
          rsp_pco_q    <= pco;
          rsp_link_q   <= link;
`ifdef JUMP_INJECT_TIMEOUT_EN
          rsp_status_q <= tmo_hit_q ? 2'b01 : 2'b00;
`else
          rsp_status_q <= 2'b00;
`endif
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          // Response fields stay put after the handshake until the next capture.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_inject_ctrl.sv
// Self-checking bench for jump_inject_ctrl. A small core model answers jumps
// with InstDone pulses and supplies capture values; commands and expected
// responses are tracked in queues.
module tb_jump_inject_ctrl;
  typedef struct packed { logic [31:0] t; logic [15:0] c; } cmd_t;
  typedef struct packed { logic [31:0] jout; logic [8:0] pco; logic [8:0] link; logic [1:0] st; } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Jen, InstDone;
  logic [31:0] Jin, Jout;
  logic [8:0]  pco, link;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;  // 0 never ready, 1 always, 2 random

  cmd_t to_send[$];
  cmd_t cmd_q[$];
  rsp_t exp_q[$];

  jump_inject_ctrl_if bus();

  jump_inject_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .Jen(Jen), .Jin(Jin),
    .InstDone(InstDone), .Jout(Jout), .pco(pco), .link(link)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic rsp_t cur_rsp();
    return '{bus.rsp_jout, bus.rsp_pco, bus.rsp_link, bus.rsp_status};
  endfunction

  task automatic junk();
    Jout = $urandom;
    pco  = 9'($urandom);
    link = 9'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    InstDone = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmd_q.delete();
    exp_q.delete();
  endtask

  // Core side: one jump per command, InstDone pulses, capture values.
  task automatic core_serve(input int n, input bit inj_noise);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      int left;
      int gap = 0;
      cmd_t c;
      rsp_t e;
      InstDone = 1'b0;
      do begin @(negedge clk); junk(); w++; end while (Jen !== 1'b1 && w < 600);
      n_tests++;
      if (Jen !== 1'b1) begin
        n_fail++; $display("FAIL jen_wait: Jen=%b after %0d cycles, required 1", Jen, w);
        return;
      end
      c = '0;
      if (cmd_q.size() == 0) begin
        n_fail++; $display("FAIL jen_spurious: jump with no accepted command");
      end else c = cmd_q.pop_front();
      n_tests++;
      if (Jin !== c.t) begin n_fail++; $display("FAIL jin: got %h required %h", Jin, c.t); end
      InstDone = inj_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      left = c.c;
      while (left > 0) begin
        @(negedge clk); junk();
        n_tests++;
        if (Jen !== 1'b0 || Jin !== 32'h0) begin
          n_fail++; $display("FAIL jen_run: Jen=%b Jin=%h required 0/0", Jen, Jin);
        end
        InstDone = (gap >= 3) || ($urandom_range(0, 2) != 0);
        if (InstDone) begin left--; gap = 0; end else gap++;
      end
      @(negedge clk);
      InstDone = 1'b0;
      junk();
      e = '{Jout, pco, link, 2'b00};
      exp_q.push_back(e);
      n_tests++;
      if (Jen !== 1'b0) begin n_fail++; $display("FAIL jen_capture: Jen=%b required 0", Jen); end
    end
    @(negedge clk); InstDone = 1'b0; junk();
  endtask

  task automatic responder(input int n);
    int   got = 0;
    int   cyc = 0;
    bit   pv  = 1'b0;
    rsp_t prev, cur, e;
    prev = '0;
    while (got < n && cyc < 3000) begin
      @(negedge clk); cyc++;
      cur = cur_rsp();
      if (pv && bus.rsp_valid === 1'b1) begin
        n_tests++;
        if (cur !== prev) begin n_fail++; $display("FAIL rsp_stable: got %h held %h", cur, prev); end
      end
      bus.rsp_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rsp_extra: unexpected response %h", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin n_fail++; $display("FAIL rsp_data: got %h required %h", cur, e); end
        end
        got++;
        pv = 1'b0;
      end else pv = (bus.rsp_valid === 1'b1);
      prev = cur;
    end
    n_tests++;
    if (got < n) begin n_fail++; $display("FAIL rsp_count: got %0d responses required %0d", got, n); end
    @(negedge clk); bus.rsp_ready = 1'b0;
  endtask

  task automatic push_driver(input bit gaps);
    int cyc = 0;
    while (to_send.size() > 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (gaps && $urandom_range(0, 2) == 0) begin bus.cmd_valid = 1'b0; continue; end
      bus.cmd_valid  = 1'b1;
      bus.cmd_target = to_send[0].t;
      bus.cmd_count  = to_send[0].c;
      if (bus.cmd_ready === 1'b1) cmd_q.push_back(to_send.pop_front());
    end
    n_tests++;
    if (to_send.size() != 0) begin n_fail++; $display("FAIL push_stall: %0d commands left, required 0", to_send.size()); end
    @(negedge clk); bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; InstDone = 1'b0; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.cmd_target = '0; bus.cmd_count = '0; junk();
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", bus.cmd_ready); end
    n_tests++;
    if (Jen !== 1'b0 || Jin !== 32'h0) begin n_fail++; $display("FAIL rst_jen: Jen=%b Jin=%h required 0/0", Jen, Jin); end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_tests++;
    if (cur_rsp() !== '0) begin n_fail++; $display("FAIL rst_rsp_regs: got %h required 0", cur_rsp()); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b required 1", bus.cmd_ready); end
    repeat (3) @(negedge clk);
    n_tests++;
    if (Jen !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: Jen=%b rsp_valid=%b required 0/0", Jen, bus.rsp_valid);
    end
  endtask

  task automatic test_basic();
    cmd_t c;
    do_reset();
    c = '{32'h40, 16'd3};
    to_send.push_back(c);
    rdy_mode = 1;
    fork
      push_driver(1'b0);
      core_serve(1, 1'b0);
      responder(1);
    join
  endtask

  task automatic test_min_latency();
    rsp_t e;
    do_reset();
    junk();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_target = 32'h0000_0A5C; bus.cmd_count = 16'd0;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %b required 1", bus.cmd_ready); end
    @(negedge clk); bus.cmd_valid = 1'b0;
    n_tests++;
    if (Jen !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_c1: Jen=%b rsp_valid=%b required 0/0", Jen, bus.rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if (Jen !== 1'b1 || Jin !== 32'h0000_0A5C) begin
      n_fail++; $display("FAIL lat_inject: Jen=%b Jin=%h required 1/00000a5c", Jen, Jin);
    end
    InstDone = 1'b1;
    @(negedge clk);
    InstDone = 1'b0;
    n_tests++;
    if (Jen !== 1'b0 || Jin !== 32'h0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_capture: Jen=%b Jin=%h rsp_valid=%b required 0/0/0", Jen, Jin, bus.rsp_valid);
    end
    junk();
    e = '{Jout, pco, link, 2'b00};
    @(negedge clk);
    junk();
    n_tests++;
    if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_rsp_valid: got %b required 1", bus.rsp_valid); end
    n_tests++;
    if (cur_rsp() !== e) begin n_fail++; $display("FAIL lat_rsp_data: got %h required %h", cur_rsp(), e); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_rsp_clear: got %b required 0", bus.rsp_valid); end
    n_tests++;
    if (cur_rsp() !== e) begin n_fail++; $display("FAIL lat_retain: got %h required %h", cur_rsp(), e); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy_mode = 0;
    fork
      begin
        cmd_t c;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          c.t = $urandom;
          c.c = 16'($urandom_range(0, 3));
          bus.cmd_valid  = (i < 5);
          bus.cmd_target = c.t;
          bus.cmd_count  = c.c;
          n_tests++;
          if (i < 5) begin
            if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b required 1", i, bus.cmd_ready); end
            else cmd_q.push_back(c);
          end else if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_full: cmd_ready got %b required 0", bus.cmd_ready);
          end
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_full: cmd_ready got %b required 0", bus.cmd_ready); end
        rdy_mode = 1;
      end
      core_serve(5, 1'b0);
      responder(5);
    join
  endtask

  task automatic test_random();
    cmd_t c;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      c.t = $urandom;
      c.c = 16'($urandom_range(0, 4));
      to_send.push_back(c);
    end
    rdy_mode = 2;
    fork
      push_driver(1'b1);
      core_serve(24, 1'b1);
      responder(24);
    join
  endtask

  task automatic test_timeout();
    int   w = 0;
    int   first = -1;
    rsp_t e;
    do_reset();
    Jout = 32'hCAFE_0001; pco = 9'h15A; link = 9'h0C3;
    e = '{32'hCAFE_0001, 9'h15A, 9'h0C3, 2'b01};
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_target = 32'h1234; bus.cmd_count = 16'd2;
    @(negedge clk); bus.cmd_valid = 1'b0;
    while (Jen !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    n_tests++;
    if (Jen !== 1'b1) begin n_fail++; $display("FAIL tmo_jen: got %b required 1", Jen); end
    @(negedge clk); InstDone = 1'b1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      InstDone = 1'b0;
      if (bus.rsp_valid === 1'b1 && first < 0) first = k;
    end
`ifdef JUMP_INJECT_TIMEOUT_EN
    n_tests++;
    if (first != 11) begin n_fail++; $display("FAIL tmo_latency: rsp_valid at cycle %0d required 11", first); end
    n_tests++;
    if (cur_rsp() !== e) begin n_fail++; $display("FAIL tmo_rsp: got %h required %h", cur_rsp(), e); end
    bus.rsp_ready = 1'b1;
    @(negedge clk); bus.rsp_ready = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b required 0", bus.rsp_valid); end
`else
    n_tests++;
    if (first != -1) begin n_fail++; $display("FAIL no_tmo: rsp_valid rose at cycle %0d, required never (%h)", first, e); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    int w = 0;
    bit seen = 1'b0;
    do_reset();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_target = 32'h100; bus.cmd_count = 16'd5;
    @(negedge clk); bus.cmd_valid = 1'b0;
    while (Jen !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    n_tests++;
    if (Jen !== 1'b1) begin n_fail++; $display("FAIL mid_jen: got %b required 1", Jen); end
    @(negedge clk);
    InstDone = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_target = 32'h101; bus.cmd_count = 16'd1;
    @(negedge clk);
    InstDone = 1'b0; bus.cmd_target = 32'h102;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_push: cmd_ready got %b required 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (Jen !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: Jen=%b rsp_valid=%b cmd_ready=%b required 0/0/0", Jen, bus.rsp_valid, bus.cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b required 1", bus.cmd_ready); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      InstDone = 1'($urandom_range(0, 1));
      if (Jen === 1'b1 || bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    InstDone = 1'b0;
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL mid_discard: jump or response after reset, required none"); end
    do_reset();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_target = '0; bus.cmd_count = '0; bus.rsp_ready = 1'b0;
    InstDone = 1'b0; junk();
    test_reset();
    test_basic();
    test_min_latency();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jump_inject_ctrl.md
JUMP_INJECT_CTRL -- requirements
Module: jump_inject_ctrl

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1024, maximum RUN cycles without an InstDone pulse.
REQ-003 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide cmd_valid  input  1  command offered.
REQ-006 SHALL provide cmd_ready  output  1  command FIFO not full.
REQ-007 SHALL provide cmd_target  input  32  jump target driven onto Jin.
REQ-008 SHALL provide cmd_count  input  16  InstDone pulses to wait for after the jump.
REQ-009 SHALL provide rsp_valid  output  1  response held.
REQ-010 SHALL provide rsp_ready  input  1  response consumed.
REQ-011 SHALL provide rsp_jout / rsp_pco / rsp_link  output  32/9/9  core Jout, pco, link captured at end of command.
REQ-012 SHALL provide rsp_status  output  2  00 OK, 01 timeout, 10/11 reserved (never driven).
REQ-013 SHALL provide Jen  output  1  jump enable to core; Jin  output  32  jump target to core.
REQ-014 SHALL provide InstDone  input  1  core instruction-retired pulse; Jout  input  32; pco  input  9; link  input  9.

Function
REQ-015 SHALL buffer commands {target, count} in a circular FIFO; push on cmd_valid & cmd_ready; pointers wrap at FIFO_DEPTH.
REQ-016 SHALL drive cmd_ready = !full from registered state only (no combinational path from pop); when full, push blocked even if pop in same cycle.
REQ-017 SHALL implement states IDLE, INJECT, RUN, CAPTURE, RESP.
REQ-018 IDLE: if FIFO non-empty, pop head, load target/count, go INJECT next edge; earliest Jen is cycle after the accepting edge.
REQ-019 INJECT: Jen=1, Jin=target for exactly one cycle; InstDone in this cycle not counted; go RUN if count!=0, else CAPTURE.
REQ-020 Outside INJECT: Jen=0, Jin=32'h0.
REQ-021 RUN: decrement count on each InstDone; on the edge sampling the InstDone that makes count 0, go CAPTURE.
REQ-022 CAPTURE: one cycle; at its closing edge latch Jout, pco, link into rsp_* registers, set rsp_status, assert rsp_valid, go RESP.
REQ-023 RESP: hold rsp_* and rsp_valid stable until rsp_valid & rsp_ready; on that edge clear rsp_valid, go IDLE.
REQ-024 rsp_* registers SHALL retain last captured values after handshake until next CAPTURE.
REQ-025 FIFO pushes SHALL continue in all states; a push and a pop in the same edge leaves occupancy unchanged.
REQ-026 Command-to-response minimum latency (count=0): rsp_valid high 3 cycles after accepting edge of an empty-FIFO push.

Reset
REQ-027 rst SHALL empty the FIFO, force IDLE, and clear count and timeout counter.
REQ-028 rst SHALL drive cmd_ready=0 during reset, then 1; Jen=0, Jin=0, rsp_valid=0, rsp_jout=0, rsp_pco=0, rsp_link=0, rsp_status=00.
REQ-029 rst asserted mid-INJECT/RUN/RESP SHALL abandon the command with no response and discard queued commands.

Configuration
REQ-030 Macro JUMP_INJECT_TIMEOUT_EN defined: RUN counts cycles, clears on each InstDone; on reaching TIMEOUT_CYCLES go CAPTURE with rsp_status=01.
REQ-031 Macro JUMP_INJECT_TIMEOUT_EN undefined: no timeout counter; RUN waits indefinitely; rsp_status always 00; TIMEOUT_CYCLES unused.

Verification
REQ-032 Push {target=32'h40, count=3}, InstDone pulses after INJECT -> one-cycle Jen with Jin=32'h40; rsp_valid after third pulse; rsp_pco/link/jout equal core values in CAPTURE; status 00.
REQ-033 Push count=0 into empty FIFO -> Jen one cycle, rsp_valid 3 cycles after accept; InstDone during INJECT ignored.
REQ-034 Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready low after 4 (FIFO_DEPTH=4) plus 1 in flight; all 5 responses delivered in order after rsp_ready=1.
REQ-035 JUMP_INJECT_TIMEOUT_EN, TIMEOUT_CYCLES=8, count=2, one InstDone then silence -> rsp_status=01 after 8 idle RUN cycles; without macro rsp_valid never rises.
REQ-036 rst asserted during RUN with 2 queued commands -> next cycle Jen=0, rsp_valid=0, FIFO empty; no response ever issued for those commands.
